down_counter_sequencer: RTL and testbench
=========================================

# down_counter_sequencer

Sequencer for the team's 3-bit down counter datapath. It accepts a start request with a load value, counts down to zero at a programmable tick rate, and emits a one-cycle `done` pulse on reaching zero. In periodic mode it reloads automatically; otherwise it returns to idle. It sits between control logic and any block needing a terminal-count event, replacing free-running counters that hard-wrap from 0 to 7.

## Interface
- `WIDTH`, 3: counter width in bits.
- `PRESCALE`, 1: clock cycles per decrement; legal range ≥1.
- `clk`  in  1: single clock; all logic updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: request a new count; honoured only in IDLE.
- `load_val`  in  WIDTH: start value, captured on an honoured `start`.
- `periodic`  in  1: captured with `start`; 1 = auto-reload after `done`.
- `stop`  in  1: abort; honoured in any non-IDLE state.
- `q`  out  WIDTH: current count.
- `busy`  out  1: high in COUNT and DONE.
- `done`  out  1: one-cycle pulse, high only in DONE.

## Operation
- States:
  - IDLE: `q`=0, `busy`=0, `done`=0.
  - COUNT.
  - DONE: `done`=1, `q`=0, `busy`=1.
- IDLE + `start`:
  - Capture `load_val` into `load_r` and `periodic` into `per_r`.
  - Set `q` = `load_val` and clear the prescaler.
  - Next state is COUNT, or DONE if `load_val` = 0.
- COUNT: on each prescaler tick, `q` ← `q`−1. The tick that takes `q` from 1 to 0 also moves the state to DONE. `q` never wraps below 0.
- DONE, one cycle only:
  - If `per_r` = 1: `q` ← `load_r`, clear the prescaler, next state is COUNT (or DONE again if `load_r` = 0).
  - Otherwise next state is IDLE.
- `stop` in COUNT or DONE: next state IDLE, `q` ← 0, no `done` pulse. `stop` in IDLE has no effect.
- `start` while not in IDLE is ignored; `load_r` and `per_r` are unchanged.
- `stop` and `start` in the same cycle: `stop` wins. From IDLE the pair is treated as a plain `start`, because `stop` is a no-op in IDLE.
- Prescaler:
  - Counts 0..`PRESCALE`−1 while in COUNT; tick is asserted when it equals `PRESCALE`−1, then it wraps to 0.
  - Held at 0 outside COUNT.
  - `PRESCALE` = 1 means a tick on every cycle.
- `rst` (highest priority, any state): state ← IDLE, `q` ← 0, prescaler ← 0, `load_r` ← 0, `per_r` ← 0. `done` and `busy` are low in the cycle after the reset edge.

## Timing
- Outputs are registered and decoded from state only; there is no combinational path from inputs to outputs.
- Honoured `start` sampled at edge E0: after E0, `q` = L and `busy` = 1.
- With `PRESCALE` = P: after edge E0+k·P, `q` = L−k. After E0+L·P, `q` = 0 and `done` = 1 for exactly one cycle.
- Load value 0: `done` = 1 immediately after E0.
- One-shot: `busy` falls at edge E0+L·P+1; a new `start` is accepted from that cycle on.
- Periodic: `q` = L again after E0+L·P+1. The `done` period is L·P+1 cycles, or 1 cycle if L = 0.
- `stop` sampled at edge Es: after Es, `busy` = 0 and `q` = 0.

## Structure
- Shared package `down_counter_pkg`: state encoding constants (IDLE = 2'd0, COUNT = 2'd1, DONE = 2'd2) and the default `WIDTH`.
- Sub-module `tick_prescaler`:
  - Parameter `PRESCALE`.
  - Ports `clk`, `rst`, `en`, `clr`, `tick`.
  - Counter width is $clog2(`PRESCALE`), minimum 1.
- Top level holds the state register, `q`, and `load_r`/`per_r`; next-state logic is a single case statement.

## Test plan
- Reset: hold `rst` for 2 cycles during an active count → `q` = 0, `busy` = 0, `done` = 0 after the edge. `start` on the first cycle after release is accepted.
- One-shot, P = 1: `start` with `load_val` = 5 → `q` = 5,4,3,2,1,0 on consecutive cycles; `done` high with `q` = 0; `busy` low one cycle later.
- Periodic, P = 1: `load_val` = 7 → `done` pulses every 8 cycles for 3 periods. Raise `stop` mid-count with `q` = 4 → `q` = 0 and `busy` = 0 next cycle, with no `done`.
- Prescale, P = 3: `load_val` = 2 → `q` holds 2 for 3 cycles, then 1 for 3 cycles, then 0 with `done`; `done` occurs 6 cycles after load.
- Zero load: `start` with `load_val` = 0 → `done` in the first cycle after the start edge. Periodic `load_val` = 0 → `done` stays high continuously until `stop`.
- Collisions: `start` with `load_val` = 6 while counting from 3 → ignored, `q` continues 2,1,0. `start` and `stop` together in COUNT → IDLE. `start` and `stop` together in IDLE → count begins.

Source files
------------

// File: rtl/down_counter_pkg.sv
// Shared definitions for the down counter sequencer: state encoding and default width.
package down_counter_pkg;

    // Sequencer states; the encoding is fixed so that external checkers can decode it.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam int DEFAULT_WIDTH = 3;

endpackage : down_counter_pkg

// File: rtl/tick_prescaler.sv
// Divides the clock into one-cycle ticks every PRESCALE cycles while enabled.
// The counter sits at 0 whenever it is disabled or cleared, so a fresh count always
// gets a full PRESCALE period before its first tick.
module tick_prescaler #(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Tick on the last count of each period; PRESCALE = 1 ticks on every enabled cycle.
    always_comb begin
        tick = en && (cnt_q == LAST);
    end

    // Next count: hold at 0 when idle or cleared, wrap to 0 after a tick.
    always_comb begin
        cnt_d = cnt_q;
        if (clr || !en) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Prescaler count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule : tick_prescaler

// File: rtl/down_counter_sequencer.sv
// Down counter sequencer: loads a start value, counts down to zero at the
// prescaled tick rate, pulses done for one cycle, then idles or reloads.
//
// Control protocol: start is a request with no acknowledge; it is honoured only
// when busy is low (IDLE), and load_val/periodic are captured on that same edge.
// A start seen while busy is dropped. stop aborts any active count without a done
// pulse and takes priority over start; in IDLE stop does nothing.
module down_counter_sequencer
    import down_counter_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] load_val,
    input  logic             periodic,
    input  logic             stop,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done
);

    // state_q is the observable FSM state for checkers and debug.
    state_e           state_q;
    state_e           state_d;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] load_r_q;
    logic [WIDTH-1:0] load_r_d;
    logic             per_r_q;
    logic             per_r_d;
    logic             pre_en;
    logic             pre_clr;
    logic             tick;

    tick_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_tick_prescaler (
        .clk  (clk),
        .rst  (rst),
        .en   (pre_en),
        .clr  (pre_clr),
        .tick (tick)
    );

    // Prescaler only runs while counting.
    always_comb begin
        pre_en = (state_q == COUNT);
    end

    // Next-state, count and captured-parameter logic.
    always_comb begin
        state_d  = state_q;
        q_d      = q_q;
        load_r_d = load_r_q;
        per_r_d  = per_r_q;
        pre_clr  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    load_r_d = load_val;
                    per_r_d  = periodic;
                    q_d      = load_val;
                    pre_clr  = 1'b1;
                    state_d  = (load_val == '0) ? DONE : COUNT;
                end
            end
            COUNT: begin
                if (stop) begin
                    state_d = IDLE;
                    q_d     = '0;
                end else if (tick && (q_q != '0)) begin
                    q_d = q_q - WIDTH'(1);
                    if (q_q == WIDTH'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (stop) begin
                    state_d = IDLE;
                    q_d     = '0;
                end else if (per_r_q) begin
                    q_d     = load_r_q;
                    pre_clr = 1'b1;
                    state_d = (load_r_q == '0) ? DONE : COUNT;
                end else begin
                    state_d = IDLE;
                    q_d     = '0;
                end
            end
            default: begin
                state_d = IDLE;
                q_d     = '0;
            end
        endcase
    end

    // State, count and captured-parameter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            q_q      <= '0;
            load_r_q <= '0;
            per_r_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            q_q      <= q_d;
            load_r_q <= load_r_d;
            per_r_q  <= per_r_d;
        end
    end

    // Outputs come straight from registers and the state decode.
    always_comb begin
        q    = q_q;
        busy = (state_q != IDLE);
        done = (state_q == DONE);
    end

endmodule : down_counter_sequencer

// File: tb/tb_down_counter_sequencer.sv
// Self-checking bench for down_counter_sequencer: expected {busy,done,q} per cycle
// is pushed when stimulus is driven and popped after the following clock edge.
module tb_down_counter_sequencer;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start;
    logic [2:0] load_val;
    logic       periodic;
    logic       stop;
    logic [2:0] q1, q3;
    logic       busy1, busy3, done1, done3;
    logic       sel3;

    down_counter_sequencer #(.WIDTH(3), .PRESCALE(1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .load_val(load_val),
        .periodic(periodic), .stop(stop), .q(q1), .busy(busy1), .done(done1)
    );

    down_counter_sequencer #(.WIDTH(3), .PRESCALE(3)) dut3 (
        .clk(clk), .rst(rst), .start(start), .load_val(load_val),
        .periodic(periodic), .stop(stop), .q(q3), .busy(busy3), .done(done3)
    );

    // ---------------- scoreboard ----------------
    logic [4:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    function automatic logic [4:0] e(input logic b, input logic d, input logic [2:0] v);
        return {b, d, v};
    endfunction

    task automatic check(input string tag, input logic [4:0] got, input logic [4:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got busy=%0b done=%0b q=%0d, expected busy=%0b done=%0b q=%0d",
                     tag, got[4], got[3], got[2:0], exp[4], exp[3], exp[2:0]);
        end
    endtask

    // ---------------- driver ----------------
    // Drive one cycle of inputs, queue the expected post-edge output, compare after the edge.
    task automatic cyc(input logic r, input logic s, input logic [2:0] lv, input logic p,
                       input logic sp, input logic [4:0] exp, input string tag);
        logic [4:0] got;
        logic [4:0] want;
        rst      = r;
        start    = s;
        load_val = lv;
        periodic = p;
        stop     = sp;
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        got  = sel3 ? {busy3, done3, q3} : {busy1, done1, q1};
        want = exp_q.pop_front();
        check(tag, got, want);
    endtask

    task automatic idle(input logic [4:0] exp, input string tag);
        cyc(1'b0, 1'b0, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'b0, exp, tag);
    endtask

    task automatic do_start(input logic [2:0] lv, input logic p, input logic [4:0] exp, input string tag);
        cyc(1'b0, 1'b1, lv, p, 1'b0, exp, tag);
    endtask

    task automatic do_stop(input logic [4:0] exp, input string tag);
        cyc(1'b0, 1'b0, 3'd0, 1'b0, 1'b1, exp, tag);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        sel3 = 1'b0;

        // Reset from power-up, then reset in the middle of an active count.
        cyc(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, e(0, 0, 0), "rst_init");
        cyc(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, e(0, 0, 0), "rst_init");
        do_start(3'd5, 1'b0, e(1, 0, 5), "pre_rst_load");
        idle(e(1, 0, 4), "pre_rst_count");
        cyc(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, e(0, 0, 0), "rst_mid");
        cyc(1'b1, 1'b1, 3'd3, 1'b0, 1'b0, e(0, 0, 0), "rst_mid_start");

        // One-shot, L=5, started on the first cycle after reset release.
        do_start(3'd5, 1'b0, e(1, 0, 5), "oneshot_load");
        for (int v = 4; v >= 1; v--) idle(e(1, 0, 3'(v)), "oneshot_count");
        idle(e(1, 1, 0), "oneshot_done");
        idle(e(0, 0, 0), "oneshot_idle");
        idle(e(0, 0, 0), "oneshot_idle2");

        // Periodic, L=7: three full periods of 8 cycles, then stop at q=4.
        do_start(3'd7, 1'b1, e(1, 0, 7), "per_load");
        for (int per = 0; per < 3; per++) begin
            for (int v = 6; v >= 1; v--) idle(e(1, 0, 3'(v)), "per_count");
            idle(e(1, 1, 0), "per_done");
            idle(e(1, 0, 7), "per_reload");
        end
        idle(e(1, 0, 6), "per_count");
        idle(e(1, 0, 5), "per_count");
        idle(e(1, 0, 4), "per_count");
        do_stop(e(0, 0, 0), "per_stop");
        idle(e(0, 0, 0), "per_stop_idle");

        // Zero load, one-shot and periodic.
        do_start(3'd0, 1'b0, e(1, 1, 0), "zero_done");
        idle(e(0, 0, 0), "zero_idle");
        do_start(3'd0, 1'b1, e(1, 1, 0), "zero_per_done");
        for (int i = 0; i < 3; i++) idle(e(1, 1, 0), "zero_per_hold");
        do_stop(e(0, 0, 0), "zero_per_stop");

        // Start while counting is ignored.
        do_start(3'd3, 1'b0, e(1, 0, 3), "coll_load");
        do_start(3'd6, 1'b1, e(1, 0, 2), "coll_ignored");
        idle(e(1, 0, 1), "coll_count");
        idle(e(1, 1, 0), "coll_done");
        idle(e(0, 0, 0), "coll_idle");

        // Ignored start must not disturb the captured reload value or mode.
        do_start(3'd2, 1'b1, e(1, 0, 2), "keep_load");
        do_start(3'd6, 1'b0, e(1, 0, 1), "keep_ignored");
        idle(e(1, 1, 0), "keep_done");
        idle(e(1, 0, 2), "keep_reload");
        do_stop(e(0, 0, 0), "keep_stop");

        // start+stop together: stop wins in COUNT, start wins in IDLE.
        do_start(3'd4, 1'b0, e(1, 0, 4), "ss_load");
        cyc(1'b0, 1'b1, 3'd6, 1'b0, 1'b1, e(0, 0, 0), "ss_count_stop");
        idle(e(0, 0, 0), "ss_idle");
        cyc(1'b0, 1'b1, 3'd3, 1'b0, 1'b1, e(1, 0, 3), "ss_idle_start");
        idle(e(1, 0, 2), "ss_count");
        do_stop(e(0, 0, 0), "ss_stop");

        // Prescale P=3 instance.
        sel3 = 1'b1;
        cyc(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, e(0, 0, 0), "p3_rst");
        do_start(3'd2, 1'b0, e(1, 0, 2), "p3_load");
        idle(e(1, 0, 2), "p3_hold2");
        idle(e(1, 0, 2), "p3_hold2");
        for (int i = 0; i < 3; i++) idle(e(1, 0, 1), "p3_hold1");
        idle(e(1, 1, 0), "p3_done");
        idle(e(0, 0, 0), "p3_idle");
        do_start(3'd1, 1'b1, e(1, 0, 1), "p3_per_load");
        idle(e(1, 0, 1), "p3_per_hold");
        idle(e(1, 0, 1), "p3_per_hold");
        idle(e(1, 1, 0), "p3_per_done");
        idle(e(1, 0, 1), "p3_per_reload");
        do_stop(e(0, 0, 0), "p3_stop");

        // ---------------- report ----------------
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_down_counter_sequencer
